// File: rtl/sr_chk_pkg.sv
// Shared types for the gated SR latch checker: FSM states and the
// input-combination decode used by the reference model.
package sr_chk_pkg;

   typedef enum logic [1:0] {
      UNINIT  = 2'd0,
      KNOWN   = 2'd1,
      CORRUPT = 2'd2
   } sr_chk_state_t;

   localparam logic [1:0] HOLD    = 2'd0;
   localparam logic [1:0] SET     = 2'd1;
   localparam logic [1:0] RST     = 2'd2;
   localparam logic [1:0] ILLEGAL = 2'd3;

   // en=0 always holds; otherwise {r,s} selects the action directly.
   function automatic logic [1:0] decode_op(input logic en, input logic s, input logic r);
      logic [1:0] op;
      op = HOLD;
      if (en) begin
         case ({r, s})
            2'b01:   op = SET;
            2'b10:   op = RST;
            2'b11:   op = ILLEGAL;
            default: op = HOLD;
         endcase
      end
      return op;
   endfunction

endpackage

// File: rtl/sr_chk_sat_cnt.sv
// Saturating up-counter with increment enable; sticks at all-ones.
module sr_chk_sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/sr_latch_checker.sv
// Clocked checker for a gated SR latch: reference model, UNINIT/KNOWN/CORRUPT
// FSM, compare and saturating counters. SR_CHK_LAG_EN selects a one-sample
// lagged compare for latches with a registered output.
module sr_latch_checker
   import sr_chk_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             s,
   input  logic             r,
   input  logic             q,
   output logic             exp_q,
   output logic             exp_valid,
   output logic             corrupt,
   output logic             err,
   output logic             illegal,
   output logic [CNT_W-1:0] chk_count,
   output logic [CNT_W-1:0] err_count
);

   sr_chk_state_t state_q, state_d;
   logic          model_q, model_d;
   logic          err_q, err_d;
   logic          illegal_q, illegal_d;
   logic          cmp_en, cmp_ref;
   logic [1:0]    op;

   always_comb begin
      op        = decode_op(en, s, r);
      state_d   = state_q;
      model_d   = model_q;
      illegal_d = 1'b0;
      case (op)
         SET: begin
            model_d = 1'b1;
            state_d = KNOWN;
         end
         RST: begin
            model_d = 1'b0;
            state_d = KNOWN;
         end
         ILLEGAL: begin
            illegal_d = 1'b1;
            state_d   = CORRUPT;
         end
         default: ;
      endcase

`ifdef SR_CHK_LAG_EN
      // Registered latch output trails by one sample, so judge it against the
      // model as it stood after the previous edge; state_q/model_q hold that.
      cmp_en  = (state_q == KNOWN);
      cmp_ref = model_q;
`else
      // Transparent latch: q already reflects this sample's update.
      cmp_en  = (state_d == KNOWN);
      cmp_ref = model_d;
`endif
      err_d = cmp_en && (q != cmp_ref);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= UNINIT;
         model_q   <= 1'b0;
         err_q     <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         model_q   <= model_d;
         err_q     <= err_d;
         illegal_q <= illegal_d;
      end
   end

   sr_chk_sat_cnt #(.W(CNT_W)) u_chk_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cmp_en),
      .cnt   (chk_count)
   );

   sr_chk_sat_cnt #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (err_d),
      .cnt   (err_count)
   );

   assign exp_q     = model_q;
   assign exp_valid = (state_q == KNOWN);
   assign corrupt   = (state_q == CORRUPT);
   assign err       = err_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_sr_latch_checker.sv
// Self-checking bench for sr_latch_checker: directed test-plan scenarios plus
// randomized stimulus against a behavioural model; a CNT_W=2 copy covers saturation.
module tb_sr_latch_checker;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0, s = 1'b0, r = 1'b0, q = 1'b0;

   logic       exp_q, exp_valid, corrupt, err, illegal;
   logic [7:0] chk_count, err_count;
   logic       exp_q2, exp_valid2, corrupt2, err2, illegal2;
   logic [1:0] chk_count2, err_count2;

   int checks = 0;
   int failures = 0;

   // Model: latch value, "has a trustworthy value", "saw S=R=1", pulses, counts.
   bit m_q, m_valid, m_corrupt, m_err, m_ill;
   int m_chk, m_errc, m_chk2, m_errc2;

   always #5 clk = ~clk;

   sr_latch_checker #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .q(q),
      .exp_q(exp_q), .exp_valid(exp_valid), .corrupt(corrupt), .err(err),
      .illegal(illegal), .chk_count(chk_count), .err_count(err_count)
   );

   sr_latch_checker #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .q(q),
      .exp_q(exp_q2), .exp_valid(exp_valid2), .corrupt(corrupt2), .err(err2),
      .illegal(illegal2), .chk_count(chk_count2), .err_count(err_count2)
   );

   function automatic int sat(input int v, input int max);
      return (v + 1 > max) ? max : v + 1;
   endfunction

   task automatic m_reset();
      m_q = 0; m_valid = 0; m_corrupt = 0; m_err = 0; m_ill = 0;
      m_chk = 0; m_errc = 0; m_chk2 = 0; m_errc2 = 0;
   endtask

   task automatic m_sample(input bit e, input bit ss, input bit rr, input bit qq);
      bit prev_q, prev_valid, do_cmp, ref_q;
      prev_q = m_q;
      prev_valid = m_valid;
      m_err = 0;
      m_ill = 0;
      if (e && ss && rr) begin
         m_ill = 1; m_valid = 0; m_corrupt = 1;
      end else if (e && (ss || rr)) begin
         m_q = ss; m_valid = 1; m_corrupt = 0;
      end
`ifdef SR_CHK_LAG_EN
      do_cmp = prev_valid; ref_q = prev_q;
`else
      do_cmp = m_valid; ref_q = m_q;
`endif
      if (do_cmp) begin
         m_chk = sat(m_chk, 255);
         m_chk2 = sat(m_chk2, 3);
         if (qq != ref_q) begin
            m_err = 1;
            m_errc = sat(m_errc, 255);
            m_errc2 = sat(m_errc2, 3);
         end
      end
   endtask

   // Drive one sample, clock it, update the model, then settle past the edge.
   task automatic step(input bit e, input bit ss, input bit rr, input bit qq);
      en = e; s = ss; r = rr; q = qq;
      @(posedge clk);
      m_sample(e, ss, rr, qq);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en = 0; s = 0; r = 0; q = 0;
      repeat (2) @(posedge clk);
      m_reset();
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({exp_q, exp_valid, corrupt, err, illegal} !== 5'b0 || chk_count !== 8'd0 ||
          err_count !== 8'd0 || chk_count2 !== 2'd0 || err_count2 !== 2'd0) begin
         failures++;
         $display("FAIL reset: flags=%b chk=%0d errc=%0d chk2=%0d errc2=%0d required all 0",
                  {exp_q, exp_valid, corrupt, err, illegal}, chk_count, err_count,
                  chk_count2, err_count2);
      end
   endtask

   task automatic test_first_set();
      step(0, 1, 0, 0);
      checks++;
      if (exp_valid !== 1'b0 || chk_count !== 8'd0) begin
         failures++;
         $display("FAIL en0_hold: exp_valid=%b chk=%0d required 0 0", exp_valid, chk_count);
      end
      step(1, 1, 0, 1);
      checks++;
      if (exp_q !== 1'b1 || exp_valid !== 1'b1 || chk_count !== 8'(m_chk) ||
          err_count !== 8'(m_errc) || err !== 1'b0) begin
         failures++;
         $display("FAIL first_set: q=%b v=%b chk=%0d errc=%0d err=%b required 1 1 %0d %0d 0",
                  exp_q, exp_valid, chk_count, err_count, err, m_chk, m_errc);
      end
   endtask

   task automatic test_hold_then_reset();
      int c0;
      c0 = int'(chk_count);
      step(1, 0, 0, 1);
      checks++;
      if (exp_q !== 1'b1 || err !== m_err) begin
         failures++;
         $display("FAIL hold: exp_q=%b err=%b required 1 %b", exp_q, err, m_err);
      end
      step(1, 0, 1, 0);
      checks++;
      if (exp_q !== 1'b0 || int'(chk_count) !== c0 + 2 || err !== m_err ||
          err_count !== 8'(m_errc)) begin
         failures++;
         $display("FAIL rst_after_hold: exp_q=%b chk=%0d err=%b errc=%0d required 0 %0d %b %0d",
                  exp_q, chk_count, err, err_count, c0 + 2, m_err, m_errc);
      end
   endtask

   task automatic test_mismatch();
      step(1, 1, 0, 0);
      checks++;
      if (err !== m_err || err_count !== 8'(m_errc) || exp_q !== 1'b1) begin
         failures++;
         $display("FAIL mismatch: err=%b errc=%0d exp_q=%b required %b %0d 1",
                  err, err_count, exp_q, m_err, m_errc);
      end
      step(1, 0, 0, 1);
      checks++;
      if (err !== m_err) begin
         failures++;
         $display("FAIL err_one_cycle: err=%b required %b", err, m_err);
      end
   endtask

   task automatic test_illegal();
      int c0, e0;
      c0 = int'(chk_count);
      e0 = int'(err_count);
      step(1, 1, 1, 0);
      checks++;
      if (illegal !== 1'b1 || corrupt !== 1'b1 || exp_valid !== 1'b0 || err !== m_err ||
          int'(chk_count) !== m_chk || int'(err_count) !== m_errc) begin
         failures++;
         $display("FAIL illegal: ill=%b cor=%b v=%b err=%b chk=%0d errc=%0d required 1 1 0 %b %0d %0d",
                  illegal, corrupt, exp_valid, err, chk_count, err_count, m_err, m_chk, m_errc);
      end
      for (int i = 0; i < 3; i++) step(0, $urandom_range(1), $urandom_range(1), $urandom_range(1));
      checks++;
      if (illegal !== 1'b0 || corrupt !== 1'b1 || exp_valid !== 1'b0 ||
          int'(chk_count) !== m_chk || int'(err_count) !== m_errc) begin
         failures++;
         $display("FAIL stay_corrupt: ill=%b cor=%b v=%b chk=%0d errc=%0d required 0 1 0 %0d %0d",
                  illegal, corrupt, exp_valid, chk_count, err_count, m_chk, m_errc);
      end
      step(1, 1, 0, 1);
      checks++;
      if (corrupt !== 1'b0 || exp_valid !== 1'b1 || exp_q !== 1'b1 || int'(chk_count) !== m_chk) begin
         failures++;
         $display("FAIL leave_corrupt: cor=%b v=%b exp_q=%b chk=%0d required 0 1 1 %0d",
                  corrupt, exp_valid, exp_q, chk_count, m_chk);
      end
      step(1, 1, 1, 0);
      step(1, 1, 1, 0);
      checks++;
      if (illegal !== 1'b1 || c0 > m_chk || e0 > m_errc) begin
         failures++;
         $display("FAIL illegal_b2b: ill=%b required 1", illegal);
      end
   endtask

   task automatic test_saturation();
      int pulses;
      pulses = 0;
      step(1, 0, 1, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, 1, 0, 0);
         if (err2 === 1'b1) pulses++;
         step(1, 0, 1, 1);
         if (err2 === 1'b1) pulses++;
      end
      checks++;
      if (err_count2 !== 2'(m_errc2) || chk_count2 !== 2'(m_chk2) || m_errc2 != 3) begin
         failures++;
         $display("FAIL saturation: chk2=%0d errc2=%0d required %0d %0d (errc must reach 3)",
                  chk_count2, err_count2, m_chk2, m_errc2);
      end
      checks++;
      if (pulses != 10) begin
         failures++;
         $display("FAIL sat_err_pulses: pulses=%0d required 10", pulses);
      end
   endtask

   task automatic test_async_reset();
      step(1, 1, 0, 0);
      @(posedge clk);
      m_sample(en, s, r, q);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({exp_q, exp_valid, corrupt, err, illegal} !== 5'b0 || chk_count !== 8'd0 ||
          err_count !== 8'd0 || chk_count2 !== 2'd0 || err_count2 !== 2'd0) begin
         failures++;
         $display("FAIL async_reset: flags=%b chk=%0d errc=%0d required all 0",
                  {exp_q, exp_valid, corrupt, err, illegal}, chk_count, err_count);
      end
      m_reset();
      en = 0; s = 0; r = 0; q = 0;
      #1 rst_n = 1'b1;
   endtask

   task automatic test_lag();
      do_reset();
      step(1, 0, 1, 0);
      step(1, 1, 0, 0);
      checks++;
`ifdef SR_CHK_LAG_EN
      if (err !== 1'b0) begin
`else
      if (err !== 1'b1) begin
`endif
         failures++;
         $display("FAIL lag_edge_n: err=%b model=%b", err, m_err);
      end
      step(0, 0, 0, 1);
      checks++;
      if (err !== 1'b0 || err !== m_err) begin
         failures++;
         $display("FAIL lag_edge_n1: err=%b required 0", err);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(99) == 0) do_reset();
         step($urandom_range(3) != 0, $urandom_range(1), $urandom_range(1), $urandom_range(1));
         checks++;
         if ({exp_q, exp_valid, corrupt, err, illegal} !== {m_q, m_valid, m_corrupt, m_err, m_ill} ||
             int'(chk_count) !== m_chk || int'(err_count) !== m_errc ||
             int'(chk_count2) !== m_chk2 || int'(err_count2) !== m_errc2 ||
             {exp_q2, exp_valid2, corrupt2, err2, illegal2} !== {m_q, m_valid, m_corrupt, m_err, m_ill}) begin
            failures++;
            $display("FAIL random[%0d]: flags=%b cnt=%0d/%0d cnt2=%0d/%0d required %b %0d/%0d %0d/%0d",
                     i, {exp_q, exp_valid, corrupt, err, illegal}, chk_count, err_count,
                     chk_count2, err_count2, {m_q, m_valid, m_corrupt, m_err, m_ill},
                     m_chk, m_errc, m_chk2, m_errc2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_set();
      test_hold_then_reset();
      test_mismatch();
      test_illegal();
      test_saturation();
      test_async_reset();
      test_lag();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
